// File: rtl/cva6_rvfi_sink.sv
// RVFI commit sink: captures retired records, tags them with a 64-bit retirement order and streams them out of a FIFO.
// Optional trap filtering is enabled by defining CVA6_RVFI_SINK_TRAP_FILTER_EN (adds trap_cnt_o).
package cva6_rvfi_sink_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic        trap;
        logic [63:0] cause;
        logic [1:0]  mode;
        logic [63:0] pc_rdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
    } rvfi_instr_t;
endpackage

module cva6_rvfi_sink #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned FifoDepth     = 8,
    parameter type rvfi_instr_t          = cva6_rvfi_sink_pkg::rvfi_instr_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  rvfi_instr_t rvfi_i [NrCommitPorts],
    input  logic        start_i,
    input  logic        stop_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output rvfi_instr_t out_rec_o,
    output logic [63:0] out_order_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o,
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
    output logic [31:0] trap_cnt_o,
`endif
    output logic [15:0] drop_cnt_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    // state    | meaning
    // IDLE     | inputs ignored, waiting for start_i
    // CAPTURE  | valid records written to the FIFO
    // DRAIN    | inputs ignored, waiting for FIFO to empty
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t state_q, state_d;

    rvfi_instr_t mem_rec [FifoDepth];
    logic [63:0] mem_ord [FifoDepth];

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, free_slots;
    logic [63:0]     order_q;
    logic            overflow_q;
    logic [15:0]     drop_cnt_q;
    logic [16:0]     drop_sum;

    logic            pop;
    logic [CntW-1:0] n_valid, n_wr, n_drop;
    logic            wr_en  [NrCommitPorts];
    logic [PtrW-1:0] wr_off [NrCommitPorts];
    logic [63:0]     wr_ord [NrCommitPorts];

`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
    logic [CntW-1:0] n_trap;
    logic [31:0]     trap_cnt_q;
    logic [32:0]     trap_sum;
    assign trap_sum   = {1'b0, trap_cnt_q} + 33'(n_trap);
    assign trap_cnt_o = trap_cnt_q;
`endif

    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign out_rec_o   = out_valid_o ? mem_rec[rd_ptr_q] : '0;
    assign out_order_o = out_valid_o ? mem_ord[rd_ptr_q] : 64'd0;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign drop_sum    = {1'b0, drop_cnt_q} + 17'(n_drop);
    // A slot freed by this cycle's pop is reusable by this cycle's push.
    assign free_slots  = CntW'(FifoDepth) - count_q + CntW'(pop);

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = 1'b0;
        unique case (state_q)
            IDLE:    if (start_i) state_d = CAPTURE;
            CAPTURE: if (stop_i)  state_d = DRAIN;
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        n_valid = '0;
        n_wr    = '0;
        n_drop  = '0;
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
        n_trap  = '0;
`endif
        for (int k = 0; k < NrCommitPorts; k++) begin
            wr_en[k]  = 1'b0;
            wr_off[k] = '0;
            wr_ord[k] = '0;
        end
        for (int k = 0; k < NrCommitPorts; k++) begin
            if (state_q == CAPTURE && rvfi_i[k].valid) begin
                wr_ord[k] = order_q + 64'(n_valid);
                n_valid   = n_valid + CntW'(1);
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
                if (rvfi_i[k].trap) n_trap = n_trap + CntW'(1);
                else
`endif
                if (n_wr < free_slots) begin
                    wr_en[k]  = 1'b1;
                    wr_off[k] = n_wr[PtrW-1:0];
                    n_wr      = n_wr + CntW'(1);
                end else begin
                    n_drop = n_drop + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrCommitPorts; k++) begin
            if (wr_en[k]) begin
                mem_rec[wr_ptr_q + wr_off[k]] <= rvfi_i[k];
                mem_ord[wr_ptr_q + wr_off[k]] <= wr_ord[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
            trap_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            wr_ptr_q <= wr_ptr_q + n_wr[PtrW-1:0];
            count_q  <= count_q + n_wr - CntW'(pop);
            order_q  <= order_q + 64'(n_valid);
            if (n_drop != '0) overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
            trap_cnt_q <= trap_sum[32] ? 32'hFFFF_FFFF : trap_sum[31:0];
`endif
        end
    end
endmodule

// File: tb/tb_cva6_rvfi_sink.sv
// Directed bench for cva6_rvfi_sink (2 commit ports, 8-entry FIFO); trap filter test runs when CVA6_RVFI_SINK_TRAP_FILTER_EN is defined.
module tb_cva6_rvfi_sink;
    import cva6_rvfi_sink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, out_valid, out_ready, busy, done, overflow;
    rvfi_instr_t rvfi [2];
    rvfi_instr_t out_rec;
    logic [63:0] out_order;
    logic [15:0] drop_cnt;
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
    logic [31:0] trap_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cva6_rvfi_sink #(.NrCommitPorts(2), .FifoDepth(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rvfi_i      (rvfi),
        .start_i     (start),
        .stop_i      (stop),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_rec_o   (out_rec),
        .out_order_o (out_order),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow),
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
        .trap_cnt_o  (trap_cnt),
`endif
        .drop_cnt_o  (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rvfi[0] = '0;
        rvfi[1] = '0;
    endtask

    task automatic set_port(input int k, input logic [63:0] pc, input logic trap);
        rvfi[k]          = '0;
        rvfi[k].valid    = 1'b1;
        rvfi[k].insn     = 32'h0000_0013;
        rvfi[k].trap     = trap;
        rvfi[k].pc_rdata = pc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        clear_in();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        clear_in();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        vectors++; if (out_order !== 64'd0) begin miscompares++; $display("FAIL reset_order got %h exp 0", out_order); end
        vectors++; if (out_rec !== '0) begin miscompares++; $display("FAIL reset_rec got %h exp 0", out_rec); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        // reset in the middle of capture discards the FIFO
        start_capture();
        set_port(0, 64'h1234, 1'b0);
        tick();
        clear_in();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        start_capture();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b exp 1", busy); end
        set_port(0, 64'h8000_0000, 1'b0);
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", out_valid); end
        vectors++; if (out_order !== 64'd0) begin miscompares++; $display("FAIL single_order got %0d exp 0", out_order); end
        vectors++; if (out_rec.pc_rdata !== 64'h8000_0000) begin miscompares++; $display("FAIL single_pc got %h exp 80000000", out_rec.pc_rdata); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_two_port();
        int idx = 0;
        do_reset();
        out_ready = 1'b1;
        start_capture();
        for (int c = 0; c < 10; c++) begin
            if (c < 3) begin
                set_port(0, 64'h1000 + 64'(c * 8), 1'b0);
                set_port(1, 64'h1004 + 64'(c * 8), 1'b0);
            end else begin
                clear_in();
            end
            tick();
            if (out_valid === 1'b1) begin
                vectors++; if (out_order !== 64'(idx)) begin miscompares++; $display("FAIL two_port_order got %0d exp %0d", out_order, idx); end
                vectors++; if (out_rec.pc_rdata !== 64'h1000 + 64'(idx * 4)) begin miscompares++; $display("FAIL two_port_pc got %h exp %h", out_rec.pc_rdata, 64'h1000 + 64'(idx * 4)); end
                idx++;
            end
        end
        vectors++; if (idx !== 6) begin miscompares++; $display("FAIL two_port_count got %0d exp 6", idx); end
    endtask

    task automatic test_overflow();
        int idx = 0;
        do_reset();
        start_capture();
        for (int c = 0; c < 5; c++) begin
            set_port(0, 64'h2000 + 64'(c * 8), 1'b0);
            set_port(1, 64'h2004 + 64'(c * 8), 1'b0);
            tick();
        end
        clear_in();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
        vectors++; if (out_order !== 64'd0) begin miscompares++; $display("FAIL ovf_head got %0d exp 0", out_order); end
        tick();
        vectors++; if (out_order !== 64'd0 || out_rec.pc_rdata !== 64'h2000) begin miscompares++; $display("FAIL ovf_hold got %0d/%h exp 0/2000", out_order, out_rec.pc_rdata); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) begin
                vectors++; if (out_order !== 64'(idx) || out_rec.pc_rdata !== 64'h2000 + 64'(idx * 4)) begin miscompares++; $display("FAIL ovf_stream got %0d/%h exp %0d", out_order, out_rec.pc_rdata, idx); end
                idx++;
            end
            tick();
        end
        vectors++; if (idx !== 8) begin miscompares++; $display("FAIL ovf_count got %0d exp 8", idx); end
        set_port(1, 64'h3000, 1'b0);
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_order !== 64'd10) begin miscompares++; $display("FAIL ovf_next_order got %b/%0d exp 1/10", out_valid, out_order); end
        vectors++; if (out_rec.pc_rdata !== 64'h3000) begin miscompares++; $display("FAIL ovf_next_pc got %h exp 3000", out_rec.pc_rdata); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        logic [63:0] exp_pc;
        do_reset();
        start_capture();
        for (int c = 0; c < 4; c++) begin
            set_port(0, 64'h4000 + 64'(c * 8), 1'b0);
            set_port(1, 64'h4004 + 64'(c * 8), 1'b0);
            tick();
        end
        clear_in();
        vectors++; if (out_order !== 64'd0) begin miscompares++; $display("FAIL full_head got %0d exp 0", out_order); end
        out_ready = 1'b1;
        set_port(0, 64'h5000, 1'b0);
        tick();
        clear_in();
        out_ready = 1'b0;
        vectors++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL full_nodrop got %0d/%b exp 0/0", drop_cnt, overflow); end
        vectors++; if (out_order !== 64'd1) begin miscompares++; $display("FAIL full_head_after got %0d exp 1", out_order); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) begin
                exp_pc = (idx == 7) ? 64'h5000 : 64'h4000 + 64'((idx + 1) * 4);
                vectors++; if (out_order !== 64'(idx + 1) || out_rec.pc_rdata !== exp_pc) begin miscompares++; $display("FAIL full_stream got %0d/%h exp %0d/%h", out_order, out_rec.pc_rdata, idx + 1, exp_pc); end
                idx++;
            end
            tick();
        end
        vectors++; if (idx !== 8) begin miscompares++; $display("FAIL full_count got %0d exp 8", idx); end
    endtask

    task automatic test_drain();
        int idx = 0;
        int dones = 0;
        do_reset();
        start_capture();
        set_port(0, 64'h6000, 1'b0);
        set_port(1, 64'h6004, 1'b0);
        tick();
        clear_in();
        set_port(0, 64'h6008, 1'b0);
        tick();
        clear_in();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL drain_enter got busy %b done %b exp 1/0", busy, done); end
        out_ready = 1'b1;
        set_port(0, 64'h7000, 1'b0);
        set_port(1, 64'h7004, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                vectors++; if (out_order !== 64'(idx) || busy !== 1'b1) begin miscompares++; $display("FAIL drain_stream got %0d busy %b exp %0d/1", out_order, busy, idx); end
                idx++;
            end
            tick();
        end
        clear_in();
        vectors++; if (idx !== 3) begin miscompares++; $display("FAIL drain_count got %0d exp 3", idx); end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL drain_done got %0d exp 1", dones); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_idle got %b exp 0", busy); end
        start_capture();
        set_port(0, 64'h8000, 1'b0);
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_order !== 64'd3) begin miscompares++; $display("FAIL drain_restart got %b/%0d exp 1/3", out_valid, out_order); end
    endtask

`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
    task automatic test_trap_filter();
        do_reset();
        out_ready = 1'b1;
        start_capture();
        set_port(0, 64'h9000, 1'b1);
        set_port(1, 64'h9004, 1'b0);
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_order !== 64'd1) begin miscompares++; $display("FAIL trap_order got %b/%0d exp 1/1", out_valid, out_order); end
        vectors++; if (out_rec.pc_rdata !== 64'h9004) begin miscompares++; $display("FAIL trap_pc got %h exp 9004", out_rec.pc_rdata); end
        vectors++; if (trap_cnt !== 32'd1 || drop_cnt !== 16'd0) begin miscompares++; $display("FAIL trap_cnt got %0d drop %0d exp 1/0", trap_cnt, drop_cnt); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL trap_empty got %b exp 0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_port();
        test_overflow();
        test_back_to_back();
        test_drain();
`ifdef CVA6_RVFI_SINK_TRAP_FILTER_EN
        test_trap_filter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
